// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : capture_ctrl
// Description : Capture sequencer for the scope sample RAM. Fills a circular
//               buffer with pre-trigger history, raises armed once enough
//               history is stored, then writes a programmed number of
//               post-trigger samples. It then pulses set_capture_done and
//               holds a sticky capture_done flag plus the trace_end address.
// Ports       : clk, rst_n (sync, active low)
//               run, clr_done, smpl_en, trig_pos[ADDR_W], triggered  (in)
//               armed, set_capture_done, capture_done, we,
//               waddr[ADDR_W], trace_end[ADDR_W]                     (out)
// Revision    : 1.0 - initial release
// ============================================================================
module capture_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              clr_done,
    input  logic              smpl_en,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              triggered,
    output logic              armed,
    output logic              set_capture_done,
    output logic              capture_done,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trace_end
);

    // Counters carry one extra bit so a full DEPTH-sample count fits.
    localparam int             c_CW    = ADDR_W + 1;
    localparam logic [c_CW-1:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W-1:0]   w_waddr_nxt;
    logic [ADDR_W-1:0]   r_trace_end;
    logic [ADDR_W-1:0]   w_trace_end_nxt;
    logic [ADDR_W-1:0]   r_tp;
    logic [ADDR_W-1:0]   w_tp_nxt;
    logic [c_CW-1:0]     r_cnt;
    logic [c_CW-1:0]     w_cnt_nxt;
    logic [c_CW-1:0]     w_cnt_inc;
    logic [c_CW-1:0]     w_pre_target;
    logic                w_write;
    logic                r_armed;
    logic                r_set_done;
    logic                r_capture_done;

    // A single counter serves both pre- and post-trigger phases; it is
    // cleared on entry to each phase.
    assign w_cnt_inc    = r_cnt + 1'b1;
    // tp = 0 yields a target of DEPTH, i.e. a full-buffer fill.
    assign w_pre_target = c_DEPTH - {1'b0, r_tp};

    assign w_write = smpl_en &&
                     ((r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST));

    always_comb begin
        w_next_state    = r_state;
        w_waddr_nxt     = r_waddr;
        w_trace_end_nxt = r_trace_end;
        w_tp_nxt        = r_tp;
        w_cnt_nxt       = r_cnt;

        // Every write consumes the current address; natural wrap at DEPTH.
        if (w_write) begin
            w_waddr_nxt = r_waddr + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_tp_nxt     = trig_pos;
                    w_waddr_nxt  = '0;
                    w_cnt_nxt    = '0;
                    w_next_state = S_PRE;
                end
            end
            S_PRE: begin
                // triggered is ignored here; armed is still low.
                if (smpl_en) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == w_pre_target) begin
                        w_next_state = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                // A strobe coinciding with the trigger is still pre-trigger
                // history; the post count starts from the next strobe.
                if (triggered) begin
                    if (r_tp != '0) begin
                        w_cnt_nxt    = '0;
                        w_next_state = S_POST;
                    end else begin
                        w_trace_end_nxt = r_waddr - 1'b1;
                        w_next_state    = S_DONE;
                    end
                end
            end
            S_POST: begin
                if (smpl_en) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == {1'b0, r_tp}) begin
                        w_trace_end_nxt = r_waddr;
                        w_next_state    = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // run is ignored here, even when it arrives with clr_done.
                if (clr_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_waddr        <= '0;
            r_trace_end    <= '0;
            r_tp           <= '0;
            r_cnt          <= '0;
            r_armed        <= 1'b0;
            r_set_done     <= 1'b0;
            r_capture_done <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_waddr        <= w_waddr_nxt;
            r_trace_end    <= w_trace_end_nxt;
            r_tp           <= w_tp_nxt;
            r_cnt          <= w_cnt_nxt;
            // Flags are registered from the next state so they line up
            // with the state they describe.
            r_armed        <= (w_next_state == S_ARMED);
            r_capture_done <= (w_next_state == S_DONE);
            r_set_done     <= (w_next_state == S_DONE) && (r_state != S_DONE);
        end
    end

    assign we               = w_write;
    assign waddr            = r_waddr;
    assign trace_end        = r_trace_end;
    assign armed            = r_armed;
    assign set_capture_done = r_set_done;
    assign capture_done     = r_capture_done;

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_ctrl
// Description : Self-checking bench for capture_ctrl (ADDR_W = 3, DEPTH = 8).
//               A write-index model predicts every output each cycle; a few
//               literal expectations pin the model for the directed cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_ctrl;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              run       = 1'b0;
    logic              clr_done  = 1'b0;
    logic              smpl_en   = 1'b0;
    logic [ADDR_W-1:0] trig_pos  = '0;
    logic              triggered = 1'b0;
    logic              armed;
    logic              set_capture_done;
    logic              capture_done;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] trace_end;

    always #5 clk = ~clk;

    capture_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .run              (run),
        .clr_done         (clr_done),
        .smpl_en          (smpl_en),
        .trig_pos         (trig_pos),
        .triggered        (triggered),
        .armed            (armed),
        .set_capture_done (set_capture_done),
        .capture_done     (capture_done),
        .we               (we),
        .waddr            (waddr),
        .trace_end        (trace_end)
    );

    // ------------------------------------------------------------------
    // Model: counts writes since the accepted run. Address of write k is
    // k mod DEPTH. Phase 0 idle, 1 pre, 2 armed, 3 post, 4 done.
    // ------------------------------------------------------------------
    int m_phase = 0;
    int m_total = 0;
    int m_trig  = 0;
    int m_tp    = 0;
    int m_te    = 0;
    int m_pulse = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_total = 0; m_trig = 0; m_tp = 0; m_te = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            case (m_phase)
                0: if (run) begin
                    m_tp = int'(trig_pos); m_total = 0; m_phase = 1;
                end
                1: if (smpl_en) begin
                    m_total++;
                    if (m_total == DEPTH - m_tp) m_phase = 2;
                end
                2: begin
                    if (triggered && m_tp == 0) begin
                        m_te = (m_total + DEPTH - 1) % DEPTH;
                        m_phase = 4; m_pulse = 1;
                    end
                    if (smpl_en) m_total++;
                    if (triggered && m_tp != 0) begin
                        m_trig = m_total; m_phase = 3;
                    end
                end
                3: if (smpl_en) begin
                    m_total++;
                    if (m_total - m_trig == m_tp) begin
                        m_te = (m_total - 1) % DEPTH;
                        m_phase = 4; m_pulse = 1;
                    end
                end
                4: if (clr_done) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    int n_pass  = 0;
    int n_total = 0;
    int npulse  = 0;
    int wq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // One cycle: compare everything against the model mid-cycle, then
    // advance to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        chk("we",               int'(we),        int'(smpl_en && m_phase >= 1 && m_phase <= 3));
        chk("waddr",            int'(waddr),     m_total % DEPTH);
        chk("armed",            int'(armed),     int'(m_phase == 2));
        chk("capture_done",     int'(capture_done), int'(m_phase == 4));
        chk("set_capture_done", int'(set_capture_done), m_pulse);
        chk("trace_end",        int'(trace_end), m_te);
        if (we) wq.push_back(int'(waddr));
        if (set_capture_done) npulse++;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_armed();
        for (int i = 0; i < 100; i++) begin
            if (armed) return;
            step();
        end
        chk("armed_timeout", 0, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (capture_done) return;
            step();
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic start(input int tp);
        wq.delete();
        npulse   = 0;
        trig_pos = ADDR_W'(tp);
        run      = 1'b1;
        step();
        run      = 1'b0;
    endtask

    task automatic clear();
        clr_done = 1'b1;
        step();
        clr_done = 1'b0;
    endtask

    int n0;
    int done_i;

    initial begin
        // Reset and idle with strobes present
        smpl_en = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("idle_we", int'(we), 0);
        chk("idle_waddr", int'(waddr), 0);
        chk("idle_armed", int'(armed), 0);
        chk("idle_done", int'(capture_done), 0);

        // Basic capture, tp = 3; trig_pos change mid-capture is ignored
        start(3);
        trig_pos = 3'd7;
        wait_armed();
        chk("basic_pre_writes", wq.size(), 5);
        step();
        triggered = 1'b1;
        step();
        wait_done();
        triggered = 1'b0;
        chk("basic_trace_end", int'(trace_end), 1);
        chk("basic_nwrites", wq.size(), 10);
        if (wq.size() == 10) begin
            chk("basic_addr7", wq[7], 7);
            chk("basic_addr8", wq[8], 0);
            chk("basic_addr9", wq[9], 1);
        end
        step();
        chk("basic_pulse", npulse, 1);
        run = 1'b1;
        step();
        run = 1'b0;
        chk("done_ignores_run", int'(capture_done), 1);
        step();
        chk("basic_pulse_once", npulse, 1);
        clear();
        chk("cleared", int'(capture_done), 0);

        // tp = 0: full fill, trigger goes straight to DONE
        start(0);
        wait_armed();
        chk("tp0_pre_writes", wq.size(), 8);
        step(); step();
        smpl_en   = 1'b0;
        triggered = 1'b1;
        step();
        triggered = 1'b0;
        smpl_en   = 1'b1;
        chk("tp0_done", int'(capture_done), 1);
        chk("tp0_trace_end", int'(trace_end), 1);
        step(); step();
        chk("tp0_no_more_we", wq.size(), 10);
        clear();

        // Strobe coincident with trigger counts as pre-trigger
        start(2);
        wait_armed();
        triggered = 1'b1;
        step();
        triggered = 1'b0;
        n0 = wq.size();
        chk("sim_pre_writes", n0, 7);
        wait_done();
        chk("sim_post_writes", wq.size() - n0, 2);
        chk("sim_trace_end", int'(trace_end), 0);
        clear();

        // Gated strobes every 3rd cycle, run pulsed mid-capture
        smpl_en = 1'b0;
        start(2);
        done_i = -1;
        for (int i = 0; i < 100; i++) begin
            if (capture_done) begin
                done_i = i;
                break;
            end
            smpl_en = (i % 3 == 0);
            if (armed) triggered = 1'b1;
            run = (i == 4);
            step();
        end
        run       = 1'b0;
        triggered = 1'b0;
        smpl_en   = 1'b1;
        chk("gated_done_cycle", done_i, 22);
        chk("gated_trace_end", int'(trace_end), 7);
        clear();

        // Reset in the middle of POST
        start(3);
        wait_armed();
        triggered = 1'b1;
        step();
        triggered = 1'b0;
        step();
        npulse = 0;
        rst_n = 1'b0;
        step();
        chk("rst_armed", int'(armed), 0);
        chk("rst_done", int'(capture_done), 0);
        chk("rst_pulse", int'(set_capture_done), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_we", int'(we), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("rst_no_pulse", npulse, 0);
        chk("rst_idle_waddr", int'(waddr), 0);

        // run together with clr_done in DONE: clear only
        start(1);
        wait_armed();
        triggered = 1'b1;
        step();
        triggered = 1'b0;
        wait_done();
        step();
        run      = 1'b1;
        clr_done = 1'b1;
        step();
        run      = 1'b0;
        clr_done = 1'b0;
        chk("rc_done", int'(capture_done), 0);
        chk("rc_we", int'(we), 0);
        step(); step(); step();
        chk("rc_stay_idle_we", int'(we), 0);
        chk("rc_stay_idle_armed", int'(armed), 0);
        chk("rc_pulse", npulse, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
